// File: rtl/msg_sched.sv
// Status text-box message scheduler: accepts message requests, switches them on
// frame ticks after a minimum hold time, blinks win messages and serves ASCII codes.
module msg_sched #(
  parameter int unsigned MIN_FRAMES   = 60,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned MSG_LEN      = 16
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       msg_valid,
  input  logic [2:0] msg_id,
  output logic       msg_ready,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  output logic       box_en,
  output logic [2:0] cur_id
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned ROW_CHARS = 16;
  localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_FRAMES);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [4:0] COL_LIMIT =
    (MSG_LEN > ROW_CHARS) ? 5'(ROW_CHARS) : 5'(MSG_LEN);
  localparam logic [6:0] SPACE = 7'h20;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t           state_q, state_nxt;
  logic             vs_q, tick_q;
  logic             pend_q, pend_nxt;
  logic [2:0]       pend_id_q, pend_id_nxt;
  logic [2:0]       cur_id_nxt;
  logic [CNT_W-1:0] hold_q, hold_nxt;
  logic [CNT_W-1:0] blink_q, blink_nxt;
  logic             phase_q, phase_nxt;
  logic             box_en_nxt;
  logic [6:0]       char_code_nxt;

  logic apply_c, accept_c, is_clear_c, blinking_c, col_ok_c;

  // Fixed 16-character message rows, space padded, no terminator.
  function automatic logic [6:0] msg_char(input logic [2:0] id, input logic [3:0] col);
    logic [127:0] row;
    logic [3:0]   idx;
    case (id)
      3'd0:    row = "PRESS START     ";
      3'd1:    row = "PLAYER X TURN   ";
      3'd2:    row = "PLAYER O TURN   ";
      3'd3:    row = "PLAYER X WINS   ";
      3'd4:    row = "PLAYER O WINS   ";
      3'd5:    row = "DRAW            ";
      default: row = {16{8'h20}};
    endcase
    idx = 4'd15 - col;
    return 7'(row >> {idx, 3'b000});
  endfunction

  assign accept_c   = msg_valid && msg_ready;
  assign is_clear_c = (pend_id_q[2:1] == 2'b11);
  assign blinking_c = (cur_id == 3'd3) || (cur_id == 3'd4);
  assign apply_c    = tick_q && pend_q && ((state_q == IDLE) || (hold_q == MIN_CNT));
  assign col_ok_c   = (char_xy[7:4] == 4'd0) && ({1'b0, char_xy[3:0]} < COL_LIMIT);

  // State register
  always_ff @(posedge pclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next state: only an applied request moves between IDLE and SHOW
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (apply_c && !is_clear_c) state_nxt = SHOW;
      SHOW:    if (apply_c && is_clear_c)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pending request, hold/blink counters and active id
  always_comb begin
    pend_nxt    = pend_q;
    pend_id_nxt = pend_id_q;
    cur_id_nxt  = cur_id;
    hold_nxt    = hold_q;
    blink_nxt   = blink_q;
    phase_nxt   = phase_q;

    if (apply_c) begin
      pend_nxt = 1'b0;
    end else if (accept_c) begin
      pend_nxt    = 1'b1;
      pend_id_nxt = msg_id;
    end

    if (apply_c) begin
      hold_nxt  = '0;
      blink_nxt = '0;
      phase_nxt = 1'b1;
      // A clear request from IDLE leaves the last shown id in place
      if (!is_clear_c || (state_q == SHOW)) cur_id_nxt = pend_id_q;
    end else if (tick_q && (state_q == SHOW)) begin
      if (hold_q != MIN_CNT) hold_nxt = hold_q + 8'd1;
      if (blinking_c) begin
        if (blink_q == BLINK_LAST) begin
          blink_nxt = '0;
          phase_nxt = ~phase_q;
        end else begin
          blink_nxt = blink_q + 8'd1;
        end
      end else begin
        blink_nxt = '0;
        phase_nxt = 1'b1;
      end
    end
  end

  // Outputs follow the next state so the character switches with cur_id
  always_comb begin
    box_en_nxt    = (state_nxt == SHOW) && phase_nxt;
    char_code_nxt = SPACE;
    if ((state_nxt == SHOW) && col_ok_c) char_code_nxt = msg_char(cur_id_nxt, char_xy[3:0]);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q      <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
      hold_q    <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b1;
      cur_id    <= '0;
      msg_ready <= 1'b1;
      box_en    <= 1'b0;
      char_code <= SPACE;
    end else begin
      vs_q      <= vsync_in;
      tick_q    <= vsync_in && !vs_q;
      pend_q    <= pend_nxt;
      pend_id_q <= pend_id_nxt;
      hold_q    <= hold_nxt;
      blink_q   <= blink_nxt;
      phase_q   <= phase_nxt;
      cur_id    <= cur_id_nxt;
      msg_ready <= !pend_nxt;
      box_en    <= box_en_nxt;
      char_code <= char_code_nxt;
    end
  end

endmodule
